// File: rtl/apb_master_bridge.sv
// APB4 master bridging a single-outstanding core request to NUM_SLAVES windowed peripherals.
// Latency 3 cycles plus wait states (1 cycle for unmapped); core holds req until the one-cycle ready pulse.
module apb_master_bridge #(
  parameter int                 ADDR_W     = 32,
  parameter int                 DATA_W     = 32,
  parameter int                 NUM_SLAVES = 4,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = 'h1000_0000,
  parameter int                 WIN_BITS   = 12,
  parameter int                 TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  output logic [DATA_W-1:0]            rdata,
  output logic                         ready,
  output logic                         err,
  output logic [ADDR_W-1:0]            PADDR,
  output logic                         PWRITE,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   wait_cnt;

  logic [ADDR_W-1:0]  offset;
  logic [ADDR_W-1:0]  window;
  logic               hit;
  logic               sel_ready;
  logic               sel_err;
  logic [DATA_W-1:0]  sel_rdata;
  logic               timed_out;

  // The subtraction wraps below BASE_ADDR, so the lower-bound compare is what rejects those.
  assign offset = addr - BASE_ADDR;
  assign window = offset >> WIN_BITS;
  assign hit    = (addr >= BASE_ADDR) && (window < ADDR_W'(NUM_SLAVES));

  assign sel_ready = PREADY[idx];
  assign sel_err   = PSLVERR[idx];
  assign sel_rdata = PRDATA[idx*DATA_W +: DATA_W];

  // The count is taken before incrementing, so ACCESS lasts TIMEOUT+1 cycles on abort.
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      wait_cnt <= '0;
      PADDR    <= '0;
      PWRITE   <= 1'b0;
      PSEL     <= '0;
      PENABLE  <= 1'b0;
      PWDATA   <= '0;
      PSTRB    <= '0;
      rdata    <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            PADDR  <= addr;
            PWRITE <= we;
            PWDATA <= wdata;
            PSTRB  <= we ? wstrb : '0;
            if (hit) begin
              idx      <= window[IDX_W-1:0];
              PSEL     <= NUM_SLAVES'(1) << window[IDX_W-1:0];
              PENABLE  <= 1'b0;
              wait_cnt <= '0;
              state    <= SETUP;
            end else begin
              rdata <= '0;
              err   <= 1'b1;
              ready <= 1'b1;
              state <= DONE;
            end
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (sel_ready) begin
            rdata   <= PWRITE ? '0 : sel_rdata;
            err     <= sel_err;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            ready   <= 1'b1;
            state   <= DONE;
          end else if (timed_out) begin
            rdata   <= '0;
            err     <= 1'b1;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            ready   <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomised scoreboard bench for apb_master_bridge: reference model predicts responses and APB setup values.
module tb_apb_master_bridge;

  localparam int     NS   = 4;
  localparam int     DW   = 32;
  localparam int     AW   = 32;
  localparam int     TO   = 4;
  localparam longint BASE = 64'h1000_0000;
  localparam longint WIN  = 4096;

  logic              clk = 1'b0;
  logic              reset;
  logic              req, we;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic [DW-1:0]     rdata;
  logic              ready, err;
  logic [AW-1:0]     PADDR;
  logic              PWRITE;
  logic [NS-1:0]     PSEL;
  logic              PENABLE;
  logic [DW-1:0]     PWDATA;
  logic [DW/8-1:0]   PSTRB;
  logic [NS*DW-1:0]  PRDATA;
  logic [NS-1:0]     PREADY, PSLVERR;

  apb_master_bridge #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_SLAVES(NS),
    .BASE_ADDR(32'h1000_0000), .WIN_BITS(12), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready), .err(err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
    int            issue;
  } resp_t;

  typedef struct {
    logic [NS-1:0]   psel;
    logic [AW-1:0]   paddr;
    logic            pwrite;
    logic [DW/8-1:0] pstrb;
    logic [DW-1:0]   pwdata;
  } bus_t;

  resp_t exp_q[$];
  bus_t  bus_q[$];
  resp_t mon_e;
  bus_t  cur_bus;
  bit    prev_done = 1'b0;

  // Slave behaviour for the transaction in flight; unselected slaves get random noise.
  int            plan_idx = 0;
  int            plan_waits = 0;
  logic          plan_serr = 1'b0;
  logic [DW-1:0] plan_rdata = '0;
  int            acc_n = 0;

  always @(negedge clk) begin
    PREADY  = NS'($urandom);
    PSLVERR = NS'($urandom);
    for (int i = 0; i < NS; i++) PRDATA[i*DW +: DW] = $urandom;
    if (PSEL[plan_idx] && PENABLE) begin
      acc_n++;
      PREADY[plan_idx] = (acc_n > plan_waits);
      if (acc_n > plan_waits) begin
        PSLVERR[plan_idx]          = plan_serr;
        PRDATA[plan_idx*DW +: DW]  = plan_rdata;
      end
    end else begin
      acc_n = 0;
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: ready=1 with nothing outstanding, expected ready=0 (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rdata", rdata, mon_e.rdata);
        chk("err", err, mon_e.err);
        chk("latency", 64'(cyc - mon_e.issue), 64'(mon_e.lat));
      end
    end
  end

  // APB bus monitor: SETUP values against the model, ACCESS values held stable.
  always @(negedge clk) begin
    if (PSEL != '0) begin
      chk("psel_onehot", 64'($onehot(PSEL)), 64'd1);
      if (!PENABLE) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_psel: PSEL=%0h with no mapped request, expected 0 (cycle %0d)", PSEL, cyc);
        end else begin
          cur_bus = bus_q.pop_front();
          chk("psel", PSEL, cur_bus.psel);
          chk("paddr", PADDR, cur_bus.paddr);
          chk("pwrite", PWRITE, cur_bus.pwrite);
          chk("pstrb", PSTRB, cur_bus.pstrb);
          chk("pwdata", PWDATA, cur_bus.pwdata);
        end
      end else begin
        chk("psel_hold", PSEL, cur_bus.psel);
        chk("paddr_hold", PADDR, cur_bus.paddr);
        chk("pwrite_hold", PWRITE, cur_bus.pwrite);
        chk("pstrb_hold", PSTRB, cur_bus.pstrb);
        chk("pwdata_hold", PWDATA, cur_bus.pwdata);
      end
    end else begin
      chk("penable_without_psel", PENABLE, 1'b0);
    end
  end

  // Reference model: decode by window arithmetic, then wait states versus timeout budget.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW/8-1:0] ws, input int waits, input logic serr,
                       input logic [DW-1:0] rd);
    longint al;
    bit     hit;
    int     idx;
    resp_t  e;
    bus_t   b;
    al  = longint'(a);
    hit = (al >= BASE) && (((al - BASE) / WIN) < NS);
    idx = hit ? int'((al - BASE) / WIN) : 0;
    req = 1'b1; we = w; addr = a; wdata = wd; wstrb = ws;
    plan_idx = idx; plan_waits = waits; plan_serr = serr; plan_rdata = rd;
    e.issue = prev_done ? cyc + 1 : cyc;
    if (!hit) begin
      e.rdata = '0; e.err = 1'b1; e.lat = 1;
    end else begin
      b.psel   = NS'(1 << idx);
      b.paddr  = a;
      b.pwrite = w;
      b.pstrb  = w ? ws : '0;
      b.pwdata = wd;
      bus_q.push_back(b);
      if (waits <= TO) begin
        e.lat = 3 + waits; e.err = serr; e.rdata = w ? '0 : rd;
      end else begin
        e.lat = 3 + TO; e.err = 1'b1; e.rdata = '0;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 40);
    checks++;
    if (!ready) begin
      errors++;
      $display("FAIL ready_wait: no ready within 40 cycles, expected ready=1");
      prev_done = 1'b0;
    end else begin
      prev_done = 1'b1;
    end
  endtask

  task automatic run(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic [DW/8-1:0] ws, input int waits, input logic serr,
                     input logic [DW-1:0] rd);
    issue(w, a, wd, ws, waits, serr, rd);
    wait_ready();
  endtask

  // req stays high through DONE and drops in the following cycle, like the core.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req = 1'b0;
      prev_done = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_psel"}, PSEL, '0);
    chk({tag, "_penable"}, PENABLE, 1'b0);
    chk({tag, "_ready"}, ready, 1'b0);
    chk({tag, "_paddr"}, PADDR, '0);
    chk({tag, "_pwrite"}, PWRITE, 1'b0);
    chk({tag, "_pwdata"}, PWDATA, '0);
    chk({tag, "_pstrb"}, PSTRB, '0);
    chk({tag, "_rdata"}, rdata, '0);
    chk({tag, "_err"}, err, 1'b0);
  endtask

  task automatic reset_abort();
    int n = 0;
    issue(1'b0, 32'h1000_2008, $urandom, 4'hF, 100, 1'b0, $urandom);
    do begin
      @(negedge clk);
      n++;
    end while (!PENABLE && n < 10);
    chk("abort_reached_access", PENABLE, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("abort");
    reset = 1'b0;
    req   = 1'b0;
    void'(exp_q.pop_back());
    prev_done = 1'b0;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    case ($urandom_range(0, 9))
      0:       a = 32'h0FFF_F000 + (32'($urandom_range(0, 1023)) << 2);
      1:       a = 32'h1000_4000 + (32'($urandom_range(0, 1023)) << 2);
      2:       a = $urandom;
      default: a = 32'h1000_0000 + (32'($urandom_range(0, 3)) << 12)
                   + (32'($urandom_range(0, 1023)) << 2);
    endcase
    return a;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    PREADY = '0; PSLVERR = '0; PRDATA = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    // Zero-wait read from slave 1
    idle(1);
    run(1'b0, 32'h1000_1004, 32'hA5A5_0001, 4'hF, 0, 1'b0, 32'hDEAD_BEEF);
    // Write to slave 3 with 3 wait states
    idle(1);
    run(1'b1, 32'h1000_3010, 32'h1234_5678, 4'b0011, 3, 1'b0, 32'hCAFE_F00D);
    // Unmapped above the last window, then below base back-to-back
    idle(1);
    run(1'b0, 32'h1000_4000, 32'h1, 4'hF, 0, 1'b0, 32'h5555_5555);
    run(1'b1, 32'h0FFF_FFFC, 32'h2, 4'hF, 0, 1'b0, 32'h6666_6666);
    // Slave error, timeout, and ready on the last allowed ACCESS cycle
    idle(2);
    run(1'b0, 32'h1000_0000, 32'h3, 4'hF, 0, 1'b1, 32'h7777_7777);
    idle(1);
    run(1'b0, 32'h1000_2000, 32'h4, 4'hF, 100, 1'b0, 32'h8888_8888);
    idle(1);
    run(1'b0, 32'h1000_2004, 32'h5, 4'hF, TO, 1'b0, 32'h9999_9999);
    idle(1);
    run(1'b1, 32'h1000_1FFC, 32'h6, 4'hC, TO + 1, 1'b0, 32'hAAAA_AAAA);
    // Back-to-back with req held through DONE
    run(1'b1, 32'h1000_0FFC, 32'h0BAD_F00D, 4'b1001, 1, 1'b0, 32'h0);
    run(1'b0, 32'h1000_3FFC, 32'h7, 4'hF, 2, 1'b0, 32'h1357_9BDF);
    run(1'b0, 32'h1000_2000, 32'h8, 4'hF, 0, 1'b0, 32'h2468_ACE0);
    // Reset during ACCESS, then a normal transfer
    idle(1);
    reset_abort();
    idle(1);
    run(1'b0, 32'h1000_1000, 32'h9, 4'hF, 1, 1'b0, 32'hFEED_FACE);

    for (int i = 0; i < 60; i++) begin
      idle($urandom_range(0, 2));
      run(1'($urandom), rand_addr(), $urandom, 4'($urandom), $urandom_range(0, TO + 2),
          1'($urandom_range(0, 4) == 0), $urandom);
    end

    idle(3);
    chk("resp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
